macro_test_sequencer: RTL and testbench
=======================================

Name: macro_test_sequencer

Overview:
- Sequences a hard GDS test macro instantiated inside a TT user wrapper.
- Accepts commands from the wrapper pins, applies one stimulus word to the macro, and waits a programmable settle time.
- Captures the macro response, compares it with an expected word, and returns the result over a valid/ready response port.
- Keeps an error count so a full test run can be scored from the pins.

Parameters:
- DW, 8, width of macro stimulus/response words.
- SW, 4, width of the settle counter; settle range is 0..2^SW-1 cycles.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00 SET_SETTLE, 01 LOAD, 10 RUN, 11 READ
- cmd_data  in  DW  operand: settle value, stimulus, expected word, or read select
- mac_en  out  1  macro strobe, one cycle per RUN
- mac_din  out  DW  stimulus to macro
- mac_dout  in  DW  macro response
- rsp_valid  out  1  response available
- rsp_ready  in  1  response accepted
- rsp_data  out  DW  response word
- rsp_err  out  1  mismatch flag of the last RUN; valid with rsp_valid
- err_cnt  out  8  saturating mismatch count
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst_n=0) clears all state:
  - state=IDLE; settle, stim, cap, exp and err_cnt =0.
  - mac_en=0, mac_din=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, cmd_ready=1.
  - Reset mid-RUN aborts immediately; no response is produced.
- A command is accepted on a clock edge with cmd_valid&&cmd_ready. Commands presented while not IDLE are ignored; the requester must hold cmd_valid.
- SET_SETTLE: settle <= cmd_data[SW-1:0]. Stays IDLE, no response.
- LOAD: stim <= cmd_data. mac_din tracks stim at all times. Stays IDLE, no response.
- RUN: exp <= cmd_data, then:
  - APPLY, 1 cycle: mac_en=1.
  - SETTLE: count settle cycles. settle=0 skips this state.
  - CAPTURE, 1 cycle: cap <= mac_dout; rsp_err <= (mac_dout!=exp); err_cnt increments on mismatch and saturates at 255.
  - RESP: rsp_valid=1, rsp_data=cap. Held until rsp_ready, then back to IDLE.
  - Latency: with acceptance at edge T, rsp_valid first asserts in the cycle after edge T+3+settle.
- READ: enters RESP next cycle.
  - cmd_data[1:0]=00: rsp_data=cap.
  - 01: rsp_data=err_cnt (zero-extended or truncated to DW).
  - 10: rsp_data=stim.
  - 11: rsp_data=MISR when the optional feature is enabled, else 0.
  - READ leaves rsp_err unchanged.
- If rsp_valid and rsp_ready are both high on an edge, the response completes and the state is IDLE after that edge. A new command can be accepted on the next edge.
- rsp_data and rsp_err must stay stable while rsp_valid=1 and rsp_ready=0.
- FSM states: IDLE, APPLY, SETTLE, CAPTURE, RESP. Any illegal encoding returns to IDLE.

Optional Feature:
- Macro: MACRO_SEQ_MISR_EN.
- Defined:
  - A DW-bit MISR (Galois, taps for x^8+x^6+x^5+x^4+1 when DW=8) folds cap in on every CAPTURE cycle.
  - MISR reset value is 8'hFF.
  - READ sel 11 returns the MISR; SET_SETTLE with cmd_data[DW-1]=1 also reseeds the MISR to 8'hFF.
- Undefined: no MISR logic; READ sel 11 returns 0; cmd_data[DW-1] of SET_SETTLE is ignored.

Decomposition:
- Package macro_seq_pkg:
  - opcode enum (SET_SETTLE, LOAD, RUN, READ).
  - state enum; read-select localparams.
  - MISR seed and tap constants.
  - ERR_MAX=255.
- Sub-module macro_seq_misr: DW-bit MISR with seed, load-enable and data input. Instantiated only under MACRO_SEQ_MISR_EN.

Test Plan:
- Reset, then check outputs → all zero except cmd_ready=1; assert rst_n=0 during SETTLE → busy drops asynchronously, no rsp_valid afterwards.
- SET_SETTLE 3, LOAD 8'hA5, RUN expecting 8'hA5 with macro loopback → mac_en pulses once, rsp_valid exactly 6 edges after acceptance, rsp_data=A5, rsp_err=0, err_cnt=0.
- SET_SETTLE 0, RUN expecting 8'h00 with macro returning 8'h3C → rsp_valid 3 edges after acceptance, rsp_err=1, err_cnt=1; READ sel 01 → 8'h01.
- Hold rsp_ready=0 for 10 cycles in RESP, issue RUN meanwhile → rsp_data stable, cmd_ready=0, extra command ignored; assert rsp_ready → IDLE next cycle.
- Perform 260 mismatching RUNs → err_cnt saturates at 255, no wrap to 0.
- With MACRO_SEQ_MISR_EN defined, reseed then capture 8'h01 then 8'h02 → READ sel 11 matches the golden model; without the macro, READ sel 11 → 8'h00.

Source files
------------

// File: rtl/macro_seq_pkg.sv
// rtl/macro_seq_pkg.sv - shared opcodes, FSM states and MISR constants for the macro test sequencer
package macro_seq_pkg;

  typedef enum logic [1:0] {
    OP_SET_SETTLE = 2'b00,
    OP_LOAD       = 2'b01,
    OP_RUN        = 2'b10,
    OP_READ       = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_APPLY   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  localparam logic [1:0] SEL_CAP  = 2'b00;
  localparam logic [1:0] SEL_ERR  = 2'b01;
  localparam logic [1:0] SEL_STIM = 2'b10;
  localparam logic [1:0] SEL_MISR = 2'b11;

  // x^8+x^6+x^5+x^4+1 with the x^8 term implied by the shift-out bit
  localparam logic [7:0] MISR_SEED = 8'hFF;
  localparam logic [7:0] MISR_TAPS = 8'h71;

  localparam logic [7:0] ERR_MAX = 8'd255;

endpackage

// File: rtl/macro_seq_misr.sv
// rtl/macro_seq_misr.sv - Galois MISR folding one data word per enabled cycle, with synchronous reseed
module macro_seq_misr #(
  parameter int DW = 8,
  parameter logic [DW-1:0] SEED = '1,
  parameter logic [DW-1:0] TAPS = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          seed_load,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] q
);

  logic [DW-1:0] shifted;

  always_comb begin
    shifted = {q[DW-2:0], 1'b0};
    if (q[DW-1]) shifted = shifted ^ TAPS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else if (seed_load) begin
      q <= SEED;
    end else if (en) begin
      q <= shifted ^ din;
    end
  end

endmodule

// File: rtl/macro_test_sequencer.sv
// rtl/macro_test_sequencer.sv - command-driven stimulus/settle/capture/compare sequencer for a hard test macro
// Optional MISR over captured words: define MACRO_SEQ_MISR_EN.
module macro_test_sequencer
  import macro_seq_pkg::*;
#(
  parameter int DW = 8,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [DW-1:0] cmd_data,
  output logic          mac_en,
  output logic [DW-1:0] mac_din,
  input  logic [DW-1:0] mac_dout,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic [7:0]    err_cnt,
  output logic          busy
);

  state_e        state, state_n;
  logic [SW-1:0] settle, cnt;
  logic [DW-1:0] stim, cap, exp_word, rd_word, misr_q;
  logic [DW+7:0] err_ext;
  op_e           op;
  logic          accept;

  assign op        = op_e'(cmd_op);
  assign accept    = cmd_valid && (state == ST_IDLE);
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign mac_en    = (state == ST_APPLY);
  assign mac_din   = stim;
  assign err_ext   = {{DW{1'b0}}, err_cnt};

`ifdef MACRO_SEQ_MISR_EN
  macro_seq_misr #(
    .DW   (DW),
    .SEED (DW'(MISR_SEED)),
    .TAPS (DW'(MISR_TAPS))
  ) u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (accept && (op == OP_SET_SETTLE) && cmd_data[DW-1]),
    .en        (state == ST_CAPTURE),
    .din       (mac_dout),
    .q         (misr_q)
  );
`else
  assign misr_q = '0;
`endif

  always_comb begin
    rd_word = '0;
    case (cmd_data[1:0])
      SEL_CAP:  rd_word = cap;
      SEL_ERR:  rd_word = err_ext[DW-1:0];
      SEL_STIM: rd_word = stim;
      SEL_MISR: rd_word = misr_q;
      default:  rd_word = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (cmd_valid && op == OP_RUN)  state_n = ST_APPLY;
        if (cmd_valid && op == OP_READ) state_n = ST_RESP;
      end
      ST_APPLY:   state_n = (settle == '0) ? ST_CAPTURE : ST_SETTLE;
      ST_SETTLE:  if (cnt == SW'(1)) state_n = ST_CAPTURE;
      ST_CAPTURE: state_n = ST_RESP;
      ST_RESP:    if (rsp_valid && rsp_ready) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // RESP spends one staging cycle with rsp_valid low before presenting the word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      settle    <= '0;
      cnt       <= '0;
      stim      <= '0;
      cap       <= '0;
      exp_word  <= '0;
      err_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (op)
              OP_SET_SETTLE: settle   <= cmd_data[SW-1:0];
              OP_LOAD:       stim     <= cmd_data;
              OP_RUN:        exp_word <= cmd_data;
              OP_READ:       rsp_data <= rd_word;
              default:       ;
            endcase
          end
        end
        ST_APPLY:  cnt <= settle;
        ST_SETTLE: cnt <= cnt - SW'(1);
        ST_CAPTURE: begin
          cap      <= mac_dout;
          rsp_data <= mac_dout;
          rsp_err  <= (mac_dout != exp_word);
          if ((mac_dout != exp_word) && (err_cnt != ERR_MAX)) err_cnt <= err_cnt + 8'd1;
        end
        ST_RESP: begin
          if (!rsp_valid)     rsp_valid <= 1'b1;
          else if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_macro_test_sequencer.sv
// tb/tb_macro_test_sequencer.sv - directed self-checking bench for macro_test_sequencer
module tb_macro_test_sequencer;

  localparam int DW = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic          mac_en;
  logic [DW-1:0] mac_din, mac_dout;
  logic          rsp_valid, rsp_ready, rsp_err, busy;
  logic [DW-1:0] rsp_data;
  logic [7:0]    err_cnt;

  logic          loopback;
  logic [DW-1:0] mac_force;
  int            vecs = 0;
  int            errs = 0;

  assign mac_dout = loopback ? mac_din : mac_force;

  always #5 clk = ~clk;

  macro_test_sequencer #(.DW(DW), .SW(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .mac_en    (mac_en),
    .mac_din   (mac_din),
    .mac_dout  (mac_dout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  task automatic issue(input logic [1:0] op, input logic [DW-1:0] d);
    bit ok = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    for (int k = 0; k < 50; k++) begin
      if (cmd_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    vecs++;
    if (ok) begin
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end else begin
      errs++;
      $display("FAIL issue_accept: cmd_ready=%0b required 1", cmd_ready);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(output int lat, output int ens);
    bit seen = 0;
    lat = 0;
    ens = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mac_en) ens++;
      if (rsp_valid) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    vecs++;
    if (!seen) begin
      errs++;
      $display("FAIL wait_rsp_timeout: rsp_valid=%0b required 1", rsp_valid);
    end
  endtask

  task automatic finish_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vecs++;
    if ({cmd_ready, mac_en, mac_din, rsp_valid, rsp_data, rsp_err, err_cnt, busy} !==
        {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0}) begin
      errs++;
      $display("FAIL reset_outputs: rdy=%0b en=%0b din=%h v=%0b d=%h e=%0b cnt=%0d busy=%0b required rdy=1 others 0",
               cmd_ready, mac_en, mac_din, rsp_valid, rsp_data, rsp_err, err_cnt, busy);
    end
  endtask

  task automatic test_run_match();
    int lat, ens;
    loopback = 1'b1;
    issue(2'b00, 8'h03);
    issue(2'b01, 8'hA5);
    issue(2'b10, 8'hA5);
    wait_rsp(lat, ens);
    vecs++;
    if (lat !== 6) begin errs++; $display("FAIL match_latency: %0d edges required 6", lat); end
    vecs++;
    if (ens !== 1) begin errs++; $display("FAIL match_mac_en: %0d pulses required 1", ens); end
    vecs++;
    if ({rsp_data, rsp_err, err_cnt} !== {8'hA5, 1'b0, 8'h00}) begin
      errs++;
      $display("FAIL match_rsp: data=%h err=%0b cnt=%0d required A5 0 0", rsp_data, rsp_err, err_cnt);
    end
    finish_rsp();
    vecs++;
    if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
      errs++;
      $display("FAIL match_idle: rdy=%0b busy=%0b v=%0b required 1 0 0", cmd_ready, busy, rsp_valid);
    end
  endtask

  task automatic test_run_mismatch();
    int lat, ens;
    loopback  = 1'b0;
    mac_force = 8'h3C;
    issue(2'b00, 8'h00);
    issue(2'b10, 8'h00);
    wait_rsp(lat, ens);
    vecs++;
    if (lat !== 3) begin errs++; $display("FAIL mismatch_latency: %0d edges required 3", lat); end
    vecs++;
    if ({rsp_data, rsp_err, err_cnt} !== {8'h3C, 1'b1, 8'h01}) begin
      errs++;
      $display("FAIL mismatch_rsp: data=%h err=%0b cnt=%0d required 3C 1 1", rsp_data, rsp_err, err_cnt);
    end
    finish_rsp();
    issue(2'b11, 8'h01);
    wait_rsp(lat, ens);
    vecs++;
    if ({rsp_data, rsp_err} !== {8'h01, 1'b1}) begin
      errs++;
      $display("FAIL read_err_cnt: data=%h err=%0b required 01 1", rsp_data, rsp_err);
    end
    finish_rsp();
    issue(2'b11, 8'h02);
    wait_rsp(lat, ens);
    vecs++;
    if (rsp_data !== 8'hA5) begin errs++; $display("FAIL read_stim: %h required A5", rsp_data); end
    finish_rsp();
    issue(2'b11, 8'h00);
    wait_rsp(lat, ens);
    vecs++;
    if (rsp_data !== 8'h3C) begin errs++; $display("FAIL read_cap: %h required 3C", rsp_data); end
    finish_rsp();
  endtask

  task automatic test_hold();
    int lat, ens;
    bit bad = 0;
    mac_force = 8'h5A;
    issue(2'b10, 8'h5A);
    wait_rsp(lat, ens);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_data  = 8'h00;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if ({rsp_valid, rsp_data, rsp_err, cmd_ready} !== {1'b1, 8'h5A, 1'b0, 1'b0}) bad = 1;
    end
    vecs++;
    if (bad) begin
      errs++;
      $display("FAIL hold_stable: v=%0b data=%h err=%0b rdy=%0b required 1 5A 0 0", rsp_valid, rsp_data, rsp_err, cmd_ready);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    vecs++;
    if ({busy, rsp_valid, cmd_ready} !== 3'b001) begin
      errs++;
      $display("FAIL hold_release: busy=%0b v=%0b rdy=%0b required 0 0 1", busy, rsp_valid, cmd_ready);
    end
    repeat (3) @(negedge clk);
    vecs++;
    if ({busy, err_cnt} !== {1'b0, 8'h01}) begin
      errs++;
      $display("FAIL hold_ignored_cmd: busy=%0b cnt=%0d required 0 1", busy, err_cnt);
    end
  endtask

  task automatic test_misr();
    int lat, ens;
    logic [DW-1:0] want;
`ifdef MACRO_SEQ_MISR_EN
    want = 8'h6F;
`else
    want = 8'h00;
`endif
    issue(2'b00, 8'h80);
    mac_force = 8'h01;
    issue(2'b10, 8'h01);
    wait_rsp(lat, ens);
    finish_rsp();
    mac_force = 8'h02;
    issue(2'b10, 8'h02);
    wait_rsp(lat, ens);
    finish_rsp();
    issue(2'b11, 8'h03);
    wait_rsp(lat, ens);
    vecs++;
    if (rsp_data !== want) begin errs++; $display("FAIL read_misr: %h required %h", rsp_data, want); end
    finish_rsp();
  endtask

  task automatic test_saturate();
    int lat, ens;
    do_reset();
    loopback  = 1'b0;
    mac_force = 8'h00;
    issue(2'b00, 8'h00);
    for (int r = 1; r <= 260; r++) begin
      issue(2'b10, 8'hFF);
      wait_rsp(lat, ens);
      finish_rsp();
      if (r == 254 || r == 255 || r == 260) begin
        vecs++;
        if (err_cnt !== ((r > 255) ? 8'd255 : 8'(r))) begin
          errs++;
          $display("FAIL saturate_%0d: cnt=%0d required %0d", r, err_cnt, (r > 255) ? 255 : r);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit bad = 0;
    issue(2'b00, 8'h0F);
    issue(2'b10, 8'h55);
    repeat (4) @(negedge clk);
    vecs++;
    if (busy !== 1'b1) begin errs++; $display("FAIL midrun_busy: %0b required 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({busy, cmd_ready, rsp_valid, err_cnt} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
      errs++;
      $display("FAIL midrun_async: busy=%0b rdy=%0b v=%0b cnt=%0d required 0 1 0 0", busy, cmd_ready, rsp_valid, err_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rsp_valid || busy) bad = 1;
    end
    vecs++;
    if (bad) begin errs++; $display("FAIL midrun_no_rsp: rsp_valid or busy seen after reset, required 0"); end
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    loopback  = 1'b0;
    mac_force = '0;
    test_reset();
    test_run_match();
    test_run_mismatch();
    test_hold();
    test_misr();
    test_saturate();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
